// File: rtl/data_ram_hs.sv
// Handshaked data RAM for the memory stage: one request in flight,
// programmable wait states, sub-word access and misalignment detection.
module data_ram_hs #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 7,
    parameter int WAIT_CYC = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_wr,
    input  logic [1:0]                            req_size,
    input  logic                                  req_sign,
    input  logic [ADDR_W-1:0]                     req_addr,
    input  logic [DATA_W-1:0]                     req_wdata,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [DATA_W-1:0]                     rsp_rdata,
    output logic                                  rsp_err,
    input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]    test_addr,
    output logic [DATA_W-1:0]                     test_data
);

    localparam int BYTES   = DATA_W / 8;
    localparam int OFF_W   = $clog2(BYTES);
    localparam int IDX_W   = ADDR_W - OFF_W;
    localparam int DEPTH   = 1 << IDX_W;
    localparam int SH_W    = OFF_W + 3;
    localparam bit NO_WAIT = (WAIT_CYC == 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                accept, fire;

    logic                wr_q, sign_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic                op_wr, op_sign, op_err;
    logic [1:0]          op_size;
    logic [ADDR_W-1:0]   op_addr;
    logic [DATA_W-1:0]   op_wdata;
    logic [OFF_W-1:0]    op_off;
    logic [IDX_W-1:0]    op_idx;
    logic [SH_W-1:0]     sh;

    logic [BYTES-1:0]    be_base, be;
    logic [DATA_W-1:0]   wsh, rd_word, shifted, keep, ld_data;
    logic                msb;

    // With no wait states the access fires on the accepting edge, so the
    // live request fields are used; otherwise the latched copy is used.
    assign op_wr    = (state_q == IDLE) ? req_wr    : wr_q;
    assign op_sign  = (state_q == IDLE) ? req_sign  : sign_q;
    assign op_size  = (state_q == IDLE) ? req_size  : size_q;
    assign op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign op_off = op_addr[OFF_W-1:0];
    assign op_idx = op_addr[ADDR_W-1:OFF_W];
    assign sh     = {op_off, 3'b000};

    // Alignment check; dword only exists on the 64-bit build.
    always_comb begin
        op_err = 1'b0;
        case (op_size)
            2'd0:    op_err = 1'b0;
            2'd1:    op_err = op_addr[0];
            2'd2:    op_err = |op_addr[1:0];
            default: op_err = (DATA_W != 64) || (|op_addr[2:0]);
        endcase
    end

    // Per-size lane mask, field mask and sign bit of the loaded field.
    always_comb begin
        be_base = '0;
        keep    = '0;
        msb     = 1'b0;
        case (op_size)
            2'd0: begin
                be_base = BYTES'(1);
                keep    = DATA_W'(8'hFF);
                msb     = shifted[7];
            end
            2'd1: begin
                be_base = BYTES'(3);
                keep    = DATA_W'(16'hFFFF);
                msb     = shifted[15];
            end
            2'd2: begin
                be_base = BYTES'(4'hF);
                keep    = DATA_W'(32'hFFFF_FFFF);
                msb     = shifted[31];
            end
            default: begin
                be_base = '1;
                keep    = '1;
                msb     = 1'b0;
            end
        endcase
    end

    assign be      = be_base << op_off;
    assign wsh     = op_wdata << sh;
    assign rd_word = mem[op_idx];
    assign shifted = rd_word >> sh;
    assign ld_data = (shifted & keep) | ((op_sign && msb) ? ~keep : '0);

    // State and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, handshake outputs and the edge that performs the access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        fire      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (NO_WAIT) begin
                        state_d = RESP;
                        fire    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYC);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    fire    = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the request fields when it is accepted.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            wr_q    <= req_wr;
            sign_q  <= req_sign;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Response register, loaded on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (fire) begin
            err_q   <= op_err;
            rdata_q <= (op_err || op_wr) ? '0 : ld_data;
        end
    end

    // Byte-lane store; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && fire && op_wr && !op_err) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[b]) mem[op_idx][b*8 +: 8] <= wsh[b*8 +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign test_data = mem[test_addr];

endmodule

// File: tb/tb_data_ram_hs.sv
// Bench for data_ram_hs: 32-bit/1-wait, 64-bit/0-wait and 32-bit/4-wait
// instances driven through one shared request bus selected by sel.
module tb_data_ram_hs;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_all, rst_c, c_rst;
    logic        req_valid;
    int          sel;
    logic        req_wr, req_sign;
    logic [1:0]  req_size;
    logic [6:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    logic [4:0]  ta32;
    logic [3:0]  ta64;

    logic        a_v, a_rdy, a_vld, a_err;
    logic [31:0] a_rd, a_td;
    logic        b_v, b_rdy, b_vld, b_err;
    logic [63:0] b_rd, b_td;
    logic        c_v, c_rdy, c_vld, c_err;
    logic [31:0] c_rd, c_td;

    assign a_v   = req_valid && (sel == 0);
    assign b_v   = req_valid && (sel == 1);
    assign c_v   = req_valid && (sel == 2);
    assign c_rst = rst_all || rst_c;

    data_ram_hs #(.DATA_W(32), .ADDR_W(7), .WAIT_CYC(1)) u_a (
        .clk(clk), .rst(rst_all), .req_valid(a_v), .req_ready(a_rdy),
        .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(a_vld), .rsp_ready(rsp_ready), .rsp_rdata(a_rd),
        .rsp_err(a_err), .test_addr(ta32), .test_data(a_td)
    );

    data_ram_hs #(.DATA_W(64), .ADDR_W(7), .WAIT_CYC(0)) u_b (
        .clk(clk), .rst(rst_all), .req_valid(b_v), .req_ready(b_rdy),
        .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_vld), .rsp_ready(rsp_ready), .rsp_rdata(b_rd),
        .rsp_err(b_err), .test_addr(ta64), .test_data(b_td)
    );

    data_ram_hs #(.DATA_W(32), .ADDR_W(7), .WAIT_CYC(4)) u_c (
        .clk(clk), .rst(c_rst), .req_valid(c_v), .req_ready(c_rdy),
        .req_wr(req_wr), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(c_vld), .rsp_ready(rsp_ready), .rsp_rdata(c_rd),
        .rsp_err(c_err), .test_addr(ta32), .test_data(c_td)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic f_rdy(int s);
        case (s)
            0:       return a_rdy;
            1:       return b_rdy;
            default: return c_rdy;
        endcase
    endfunction

    function automatic logic f_vld(int s);
        case (s)
            0:       return a_vld;
            1:       return b_vld;
            default: return c_vld;
        endcase
    endfunction

    function automatic logic f_err(int s);
        case (s)
            0:       return a_err;
            1:       return b_err;
            default: return c_err;
        endcase
    endfunction

    function automatic logic [63:0] f_rd(int s);
        case (s)
            0:       return {32'h0, a_rd};
            1:       return b_rd;
            default: return {32'h0, c_rd};
        endcase
    endfunction

    // One full transaction, entered and left just after a falling edge.
    task automatic xact(input string tag, input int s, input bit wr,
                        input logic [1:0] sz, input bit sg,
                        input logic [6:0] addr, input logic [63:0] wd,
                        input int bp, input logic [63:0] er,
                        input bit ee, input int el);
        int lat;
        sel = s;
        chk({tag, " req_ready idle"}, 64'(f_rdy(s)), 64'd1);
        req_wr    = wr;
        req_size  = sz;
        req_sign  = sg;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        rsp_ready = (bp == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!f_vld(s) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(el));
        if (!f_vld(s)) return;
        chk({tag, " rdata"}, f_rd(s), er);
        chk({tag, " err"}, 64'(f_err(s)), 64'(ee));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, " hold valid"}, 64'(f_vld(s)), 64'd1);
            chk({tag, " hold rdata"}, f_rd(s), er);
            chk({tag, " hold ready"}, 64'(f_rdy(s)), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " ready after"}, 64'(f_rdy(s)), 64'd1);
        chk({tag, " valid after"}, 64'(f_vld(s)), 64'd0);
    endtask

    // Byte-array reference for the 32-bit instance.
    logic [7:0] mb [128];

    function automatic logic [31:0] m_load(logic [6:0] a, logic [1:0] sz,
                                           bit sg);
        int nb = 1 << sz;
        logic [31:0] v = 32'h0;
        for (int i = 0; i < nb; i++) v |= 32'(mb[int'(a) + i]) << (8 * i);
        if (sg && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] m_word(int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    typedef struct {
        bit          wr;
        logic [1:0]  sz;
        bit          sg;
        logic [6:0]  addr;
        logic [31:0] wd;
        logic [31:0] er;
        bit          ee;
        logic [31:0] w1;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  addr;
        logic [1:0]  sz;
        logic [31:0] wd, er;
        bit          wr, sg, ee;
        int          nb, bp, tw;
        bit          seen;

        tbl[0]  = '{1, 2'd2, 0, 7'h04, 32'h12345678, 32'h0, 0, 32'h12345678};
        tbl[1]  = '{0, 2'd2, 0, 7'h04, 32'h0, 32'h12345678, 0, 32'h12345678};
        tbl[2]  = '{1, 2'd0, 0, 7'h05, 32'hFFFFFFAB, 32'h0, 0, 32'h1234AB78};
        tbl[3]  = '{0, 2'd0, 1, 7'h05, 32'h0, 32'hFFFFFFAB, 0, 32'h1234AB78};
        tbl[4]  = '{0, 2'd0, 0, 7'h05, 32'h0, 32'h000000AB, 0, 32'h1234AB78};
        tbl[5]  = '{0, 2'd1, 1, 7'h04, 32'h0, 32'hFFFFAB78, 0, 32'h1234AB78};
        tbl[6]  = '{1, 2'd2, 0, 7'h06, 32'hCAFEF00D, 32'h0, 1, 32'h1234AB78};
        tbl[7]  = '{0, 2'd1, 0, 7'h03, 32'h0, 32'h0, 1, 32'h1234AB78};
        tbl[8]  = '{0, 2'd3, 0, 7'h04, 32'h0, 32'h0, 1, 32'h1234AB78};
        tbl[9]  = '{0, 2'd1, 0, 7'h06, 32'h0, 32'h00001234, 0, 32'h1234AB78};
        tbl[10] = '{1, 2'd1, 0, 7'h06, 32'h0000BEEF, 32'h0, 0, 32'hBEEFAB78};
        tbl[11] = '{0, 2'd2, 1, 7'h04, 32'h0, 32'hBEEFAB78, 0, 32'hBEEFAB78};
        tbl[12] = '{0, 2'd0, 1, 7'h07, 32'h0, 32'hFFFFFFBE, 0, 32'hBEEFAB78};
        tbl[13] = '{1, 2'd3, 0, 7'h08, 32'h11111111, 32'h0, 1, 32'hBEEFAB78};

        rst_all   = 1'b1;
        rst_c     = 1'b0;
        req_valid = 1'b0;
        sel       = 0;
        req_wr    = 1'b0;
        req_sign  = 1'b0;
        req_size  = 2'd0;
        req_addr  = 7'h0;
        req_wdata = 64'h0;
        rsp_ready = 1'b0;
        ta32      = 5'd1;
        ta64      = 4'd1;
        repeat (3) @(negedge clk);
        rst_all = 1'b0;
        @(negedge clk);

        chk("reset req_ready", 64'(a_rdy), 64'd1);
        chk("reset rsp_valid", 64'(a_vld), 64'd0);
        chk("reset rsp_rdata", 64'(a_rd), 64'd0);
        chk("reset rsp_err", 64'(a_err), 64'd0);
        chk("reset b req_ready", 64'(b_rdy), 64'd1);

        for (int i = 0; i < 14; i++) begin
            xact($sformatf("tbl%0d", i), 0, tbl[i].wr, tbl[i].sz,
                 tbl[i].sg, tbl[i].addr, 64'(tbl[i].wd), 0,
                 64'(tbl[i].er), tbl[i].ee, 2);
            chk($sformatf("tbl%0d word1", i), 64'(a_td), 64'(tbl[i].w1));
        end

        xact("backpressure", 0, 1'b0, 2'd2, 1'b0, 7'h04, 64'h0, 5,
             64'hBEEFAB78, 1'b0, 2);

        for (int w = 0; w < 32; w++) begin
            wd = $urandom;
            xact($sformatf("init%0d", w), 0, 1'b1, 2'd2, 1'b0, 7'(4 * w),
                 64'(wd), 0, 64'h0, 1'b0, 2);
            for (int i = 0; i < 4; i++) mb[4*w+i] = wd[8*i +: 8];
        end

        for (int n = 0; n < 150; n++) begin
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom_range(0, 1));
            addr = 7'($urandom);
            if ($urandom_range(0, 3) != 0)
                addr = addr & ~7'((1 << sz) - 1);
            wd = $urandom;
            bp = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            nb = 1 << sz;
            ee = (sz == 2'd3) || ((int'(addr) % nb) != 0);
            er = (ee || wr) ? 32'h0 : m_load(addr, sz, sg);
            tw = $urandom_range(0, 31);
            ta32 = 5'(tw);
            xact($sformatf("rand%0d", n), 0, wr, sz, sg, addr, 64'(wd), bp,
                 64'(er), ee, 2);
            if (wr && !ee)
                for (int i = 0; i < nb; i++) mb[int'(addr)+i] = wd[8*i +: 8];
            chk($sformatf("rand%0d test_data", n), 64'(a_td),
                64'(m_word(tw)));
        end

        ta64 = 4'd1;
        xact("b dstore", 1, 1'b1, 2'd3, 1'b0, 7'h08,
             64'h0123456789ABCDEF, 0, 64'h0, 1'b0, 1);
        chk("b test_data", b_td, 64'h0123456789ABCDEF);
        xact("b lw 0C", 1, 1'b0, 2'd2, 1'b1, 7'h0C, 64'h0, 0,
             64'h0000000001234567, 1'b0, 1);
        xact("b lw 08", 1, 1'b0, 2'd2, 1'b1, 7'h08, 64'h0, 0,
             64'hFFFFFFFF89ABCDEF, 1'b0, 1);
        xact("b lhu 0A", 1, 1'b0, 2'd1, 1'b0, 7'h0A, 64'h0, 0,
             64'h00000000000089AB, 1'b0, 1);
        xact("b ld 0C", 1, 1'b0, 2'd3, 1'b0, 7'h0C, 64'h0, 0,
             64'h0, 1'b1, 1);
        xact("b ld 08 bp", 1, 1'b0, 2'd3, 1'b0, 7'h08, 64'h0, 2,
             64'h0123456789ABCDEF, 1'b0, 1);

        ta32 = 5'd2;
        xact("c init", 2, 1'b1, 2'd2, 1'b0, 7'h08, 64'h11112222, 0,
             64'h0, 1'b0, 5);
        chk("c init word2", 64'(c_td), 64'h11112222);

        sel       = 2;
        req_wr    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 7'h08;
        req_wdata = 64'hDEADBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        chk("c abort req_ready", 64'(c_rdy), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (c_vld) seen = 1'b1;
        end
        chk("c abort no response", 64'(seen), 64'd0);
        chk("c abort word2", 64'(c_td), 64'h11112222);

        req_wdata = 64'h55555555;
        rst_c     = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        rst_c     = 1'b0;
        req_valid = 1'b0;
        chk("c rst+req ready", 64'(c_rdy), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (c_vld) seen = 1'b1;
        end
        chk("c rst+req no response", 64'(seen), 64'd0);
        chk("c rst+req word2", 64'(c_td), 64'h11112222);

        xact("c load", 2, 1'b0, 2'd2, 1'b0, 7'h08, 64'h0, 0,
             64'h11112222, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
